// File: rtl/fft_frame_streamer.sv
`default_nettype none
// =============================================================================
// Module   : fft_frame_streamer
// Brief    : Frames a complex sample stream into FFT_LEN-point Avalon-ST packets,
//            latches FFT/IFFT mode per frame and zero-pads frames cut by flush.
//            Define CP_REMOVE_EN to strip CP_LEN cyclic-prefix samples per symbol.
// Revision : 1.0 - initial release
// =============================================================================
module fft_frame_streamer #(
   parameter int DATA_W  = 8,
   parameter int FFT_LEN = 64,
   parameter int CP_LEN  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_re,
   input  logic [DATA_W-1:0] in_im,
   input  logic              in_inverse,
   input  logic              flush,
   output logic              sink_valid,
   input  logic              sink_ready,
   output logic              sink_sop,
   output logic              sink_eop,
   output logic [DATA_W-1:0] sink_real,
   output logic [DATA_W-1:0] sink_imag,
   output logic              inverse,
   output logic [1:0]        sink_error,
   output logic [15:0]       frame_count
);

   localparam int                 c_IDX_W = $clog2(FFT_LEN);
   localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(FFT_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_PAD  = 2'd2,
      S_DROP = 2'd3
   } state_t;

   generate
      if (FFT_LEN < 8 || FFT_LEN > 1024 || (FFT_LEN & (FFT_LEN - 1)) != 0 ||
          CP_LEN < 1 || CP_LEN >= FFT_LEN) begin : g_bad_param
         $error("fft_frame_streamer: illegal FFT_LEN or CP_LEN");
      end
   endgenerate

`ifdef CP_REMOVE_EN
   // Every symbol, including the first after reset, opens with its prefix.
   localparam state_t             c_FRAME_DONE = S_DROP;
   localparam logic [c_IDX_W-1:0] c_CP_LAST    = c_IDX_W'(CP_LEN - 1);
   logic [c_IDX_W-1:0]            r_dcnt;
`else
   localparam state_t c_FRAME_DONE = S_IDLE;
`endif

   state_t              r_state;
   state_t              w_next;
   logic                w_load;
   logic                w_ready;
   logic                w_ld_smp;
   logic                w_ld_pad;
   logic [c_IDX_W-1:0]  r_idx;
   logic                r_valid;
   logic                r_sop;
   logic                r_eop;
   logic                r_inv;
   logic [DATA_W-1:0]   r_re;
   logic [DATA_W-1:0]   r_im;
   logic [15:0]         r_fcnt;

   assign w_load = ~r_valid | sink_ready;

   always_ff @(posedge clk) begin
      if (reset) r_state <= c_FRAME_DONE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_ready  = 1'b0;
      w_ld_smp = 1'b0;
      w_ld_pad = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready  = w_load;
            w_ld_smp = in_valid & w_load;
            if (w_ld_smp) w_next = S_RUN;
         end
         S_RUN: begin
            w_ready  = w_load;
            w_ld_smp = in_valid & w_load;
            // A sample arriving with flush is taken first; if it closes the frame, no padding.
            if (w_ld_smp && r_idx == c_LAST) w_next = c_FRAME_DONE;
            else if (flush)                  w_next = S_PAD;
         end
         S_PAD: begin
            w_ld_pad = w_load;
            if (w_load && r_idx == c_LAST) w_next = c_FRAME_DONE;
         end
         default: begin
`ifdef CP_REMOVE_EN
            w_ready = 1'b1;
            if (!flush && in_valid && r_dcnt == c_CP_LAST) w_next = S_IDLE;
`endif
         end
      endcase
      if (reset) w_ready = 1'b0;
   end

`ifdef CP_REMOVE_EN
   always_ff @(posedge clk) begin
      if (reset || r_state != S_DROP || flush) r_dcnt <= '0;
      else if (in_valid)                       r_dcnt <= (r_dcnt == c_CP_LAST) ? '0 : r_dcnt + 1'b1;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
         r_inv   <= 1'b0;
         r_re    <= '0;
         r_im    <= '0;
         r_fcnt  <= '0;
      end else begin
         if (w_ld_smp || w_ld_pad) begin
            r_valid <= 1'b1;
            r_sop   <= (r_idx == '0);
            r_eop   <= (r_idx == c_LAST);
            r_re    <= w_ld_smp ? in_re : '0;
            r_im    <= w_ld_smp ? in_im : '0;
            r_idx   <= (r_idx == c_LAST) ? '0 : r_idx + 1'b1;
         end else if (sink_ready) begin
            r_valid <= 1'b0;
         end
         if (w_ld_smp && r_state == S_IDLE) r_inv <= in_inverse;
         if (r_valid && sink_ready && r_eop) r_fcnt <= r_fcnt + 16'd1;
      end
   end

   assign in_ready    = w_ready;
   assign sink_valid  = r_valid;
   assign sink_sop    = r_sop;
   assign sink_eop    = r_eop;
   assign sink_real   = r_re;
   assign sink_imag   = r_im;
   assign inverse     = r_inv;
   assign sink_error  = 2'b00;
   assign frame_count = r_fcnt;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_streamer.sv
`default_nettype none
// =============================================================================
// Module   : tb_fft_frame_streamer
// Brief    : Scoreboard bench for fft_frame_streamer (CP_REMOVE_EN aware).
// Revision : 1.0 - initial release
// =============================================================================
module tb_fft_frame_streamer;
   localparam int DATA_W  = 8;
   localparam int FFT_LEN = 64;
   localparam int CP_LEN  = 16;
`ifdef CP_REMOVE_EN
   localparam int PRE = CP_LEN;
`else
   localparam int PRE = 0;
`endif
   localparam int SYM = PRE + FFT_LEN;

   logic              clk        = 1'b0;
   logic              reset      = 1'b1;
   logic              in_valid   = 1'b0;
   logic              in_inverse = 1'b0;
   logic              flush      = 1'b0;
   logic [DATA_W-1:0] in_re      = '0;
   logic [DATA_W-1:0] in_im      = '0;
   logic              sink_ready;
   logic              in_ready;
   logic              sink_valid;
   logic              sink_sop;
   logic              sink_eop;
   logic [DATA_W-1:0] sink_real;
   logic [DATA_W-1:0] sink_imag;
   logic              inverse;
   logic [1:0]        sink_error;
   logic [15:0]       frame_count;

   fft_frame_streamer #(.DATA_W(DATA_W), .FFT_LEN(FFT_LEN), .CP_LEN(CP_LEN)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_re(in_re), .in_im(in_im), .in_inverse(in_inverse), .flush(flush),
      .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_sop(sink_sop),
      .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
      .inverse(inverse), .sink_error(sink_error), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
   endtask

   // 0: ready high, 1: random, 2: held low
   int bp_mode = 0;
   initial begin
      sink_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (bp_mode)
            0:       sink_ready = 1'b1;
            1:       sink_ready = 1'($urandom_range(0, 1));
            default: sink_ready = 1'b0;
         endcase
      end
   end

   function automatic logic [31:0] pack(input logic s, input logic e, input logic i,
                                        input logic [7:0] re, input logic [7:0] im);
      return {12'd0, 1'b1, s, e, i, re, im};
   endfunction

   function automatic logic [7:0] dre(input int base, input int k);
      return 8'(base + k);
   endfunction

   function automatic logic [7:0] dim(input int base, input int k);
      return 8'((base * 5) ^ (k * 3));
   endfunction

   // Reference model: frame-level behaviour observed at the negative edge.
   logic [31:0] q[$];
   int          m_idx      = 0;
   int          m_dcnt     = 0;
   logic        m_inv      = 1'b0;
   logic        m_drop     = (PRE != 0);
   logic        prev_stall = 1'b0;
   logic [31:0] prev_out   = '0;

   always @(negedge clk) begin
      logic [31:0] cur;
      logic [31:0] e_val;
      cur = {12'd0, sink_valid, sink_sop, sink_eop, inverse, sink_real, sink_imag};
      if (prev_stall && !reset) chk("hold", cur, prev_out);
      if (!reset && sink_valid && !sink_ready && !m_drop) chk("stall_rdy", 32'(in_ready), 0);
      if (sink_valid && sink_ready) begin
         if (q.size() == 0) chk("unexpected_out", cur, 0);
         else begin
            e_val = q.pop_front();
            chk("out", cur, e_val);
         end
      end
      prev_stall = !reset && sink_valid && !sink_ready;
      prev_out   = cur;
      if (reset) begin
         q.delete();
         m_idx  = 0;
         m_dcnt = 0;
         m_inv  = 1'b0;
         m_drop = (PRE != 0);
      end else if (m_drop) begin
         if (flush) m_dcnt = 0;
         else if (in_valid && in_ready) begin
            m_dcnt++;
            if (m_dcnt == PRE) begin
               m_drop = 1'b0;
               m_dcnt = 0;
            end
         end
      end else begin
         if (in_valid && in_ready) begin
            if (m_idx == 0) m_inv = in_inverse;
            q.push_back(pack(m_idx == 0, m_idx == FFT_LEN - 1, m_inv, in_re, in_im));
            m_idx++;
            if (m_idx == FFT_LEN) begin
               m_idx  = 0;
               m_drop = (PRE != 0);
            end
         end
         if (flush && m_idx != 0) begin
            while (m_idx < FFT_LEN) begin
               q.push_back(pack(1'b0, m_idx == FFT_LEN - 1, m_inv, 8'd0, 8'd0));
               m_idx++;
            end
            m_idx  = 0;
            m_drop = (PRE != 0);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] re, input logic [7:0] im, input logic inv);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      in_valid = 1'b1; in_re = re; in_im = im; in_inverse = inv;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         cyc();
         n++;
      end
      in_valid = 1'b0;
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   // inv_mode: 0 = low, 1 = high, 2 = high at sop then toggling
   task automatic send_run(input int first, input int count, input int base,
                           input int inv_mode, input bit gaps);
      logic inv;
      for (int k = first; k < first + count; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) cyc();
         case (inv_mode)
            0:       inv = 1'b0;
            1:       inv = 1'b1;
            default: inv = (k == PRE) ? 1'b1 : 1'(k % 2);
         endcase
         send(dre(base, k), dim(base, k), inv);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || sink_valid) && n < 1000) begin
         cyc();
         n++;
      end
      if (n >= 1000) chk("drain_timeout", 32'(q.size()), 0);
   endtask

   task automatic rst_checks(input string tag);
      chk({tag, "_ctl"}, {28'd0, sink_valid, sink_sop, sink_eop, inverse}, 0);
      chk({tag, "_data"}, {16'd0, sink_real, sink_imag}, 0);
      chk({tag, "_fcnt"}, 32'(frame_count), 0);
      chk({tag, "_rdy"}, 32'(in_ready), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) cyc();
      @(negedge clk);
      rst_checks("reset");
      chk("sink_error", 32'(sink_error), 0);
      cyc();
      reset = 1'b0;

      // T1: one clean frame
      send_run(0, SYM, 0, 0, 1'b0);
      drain();
      chk("t1_fcnt", 32'(frame_count), 1);

      // T2: three-cycle stall while sample 10 sits on the output
      send_run(0, PRE + 11, 16, 0, 1'b0);
      bp_mode = 2;
      in_valid = 1'b1; in_re = dre(16, PRE + 11); in_im = dim(16, PRE + 11);
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk("t2_rdy", 32'(in_ready), 0);
         chk("t2_data", {24'd0, sink_real}, {24'd0, dre(16, PRE + 10)});
         if (s == 2) bp_mode = 0;
      end
      cyc();
      send_run(PRE + 11, FFT_LEN - 11, 16, 0, 1'b0);
      drain();
      chk("t2_fcnt", 32'(frame_count), 2);

      // T3: mode latched at sop, then the next frame picks up its own mode
      send_run(0, SYM, 32, 2, 1'b0);
      send_run(0, SYM, 48, 0, 1'b0);
      drain();
      chk("t3_fcnt", 32'(frame_count), 4);

      // T4: flush after 20 samples pads the rest with zeros
      send_run(0, PRE + 20, 64, 1, 1'b0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      begin
         int  n;
         bit  done;
         n    = 0;
         done = 1'b0;
         while (!done && n < 300) begin
            @(negedge clk);
            if (sink_valid && sink_eop) done = 1'b1;
            else chk("t4_pad_rdy", 32'(in_ready), 0);
            cyc();
            n++;
         end
         if (!done) chk("t4_timeout", 0, 1);
      end
      drain();
      chk("t4_fcnt", 32'(frame_count), 5);

      // Flush coinciding with eop, then flush between frames: neither pads
      send_run(0, SYM - 1, 80, 0, 1'b0);
      flush = 1'b1;
      send(dre(80, SYM - 1), dim(80, SYM - 1), 1'b0);
      flush = 1'b0;
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      send_run(0, SYM, 96, 1, 1'b0);
      drain();
      chk("t4b_fcnt", 32'(frame_count), 7);

      // T5: reset mid-frame discards it; the next frame realigns
      send_run(0, PRE + 30, 112, 0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_checks("t5");
      cyc();
      reset = 1'b0;
      send_run(0, SYM, 128, 1, 1'b0);
      drain();
      chk("t5_fcnt", 32'(frame_count), 1);

      // Random backpressure and input gaps, including a flushed frame
      bp_mode = 1;
      send_run(0, SYM, 144, 1, 1'b1);
      send_run(0, PRE + 40, 160, 0, 1'b1);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      send_run(0, SYM, 176, 2, 1'b1);
      drain();
      bp_mode = 0;
      repeat (2) cyc();
      chk("rand_fcnt", 32'(frame_count), 4);
      chk("rand_queue", 32'(q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
